icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the datapath fetch stage and the memory controller's instruction port (iREN/iaddr/iwait/iload).
- Hits are served combinationally from a 16-frame, one-word-per-frame array.
- Misses run a single-word fill from RAM through the memory controller. The memory controller may hold iwait high for many cycles while data traffic is prioritised.

Parameters:
- FRAMES, 16, number of frames; power of two. Index = imemaddr[IDX+1:2], where IDX = log2(FRAMES).
- CNTW, 32, width of the hit and miss performance counters.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-high reset.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  32  datapath fetch byte address; bits [1:0] ignored.
- flush  input  1  invalidate all frames.
- ihit  output  1  imemload is valid this cycle.
- imemload  output  32  instruction word.
- iREN  output  1  read request to memory controller.
- iaddr  output  32  word-aligned fill address to memory controller.
- iwait  input  1  memory controller stall; low means iload is valid this cycle.
- iload  input  32  fill data from memory controller.
- hit_count  output  CNTW  number of cycles with ihit=1.
- miss_count  output  CNTW  number of fills started.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset (any cycle, including mid-fill):
  - All valid bits, tags and data cleared to 0; state IDLE; counters 0; miss-address register 0.
  - Resulting outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
- Address fields: tag = imemaddr[31:IDX+2]; idx = imemaddr[IDX+1:2].
- hit = (state==IDLE) & imemREN & valid[idx] & (tag[idx]==addr tag).
- ihit = hit (combinational). imemload = data[idx] always, regardless of ihit.
- FSM states: IDLE, FETCH.
  - IDLE, imemREN=1, no hit: latch {imemaddr[31:2],2'b00} into missaddr; go to FETCH; miss_count += 1.
  - IDLE, otherwise: stay in IDLE.
  - FETCH: iREN=1 and iaddr=missaddr every cycle.
    - iwait=1: stay in FETCH.
    - iwait=0: write frame[missaddr idx] with valid=1, tag=missaddr tag, data=iload; go to IDLE.
  - iREN=0 and iaddr=0 whenever state is IDLE.
- Latency:
  - Hit: same cycle as the request.
  - Miss: request cycle, then N FETCH cycles (last one has iwait=0), then hit in the following IDLE cycle. Minimum miss-to-ihit is 2 cycles.
- Fill address is the latched missaddr, not the live imemaddr.
  - If imemaddr changes or imemREN drops during FETCH, the fill still completes to missaddr.
  - IDLE then re-evaluates the current imemaddr; it may immediately miss again.
- Fills cannot be aborted except by reset.
- Conflict: a fill overwrites whatever occupied the frame; no replacement choice.
- flush: synchronous; clears all valid bits at the clock edge; highest priority.
  - If flush coincides with fill completion, the filled frame ends invalid. Tag/data may be written; valid must be 0.
  - A flush during FETCH does not change state. A fill completing on a later cycle is written valid.
  - During the flush cycle itself, ihit still reflects pre-flush valid bits.
- Counters: free-running, wrap modulo 2^CNTW.
  - hit_count += 1 on each cycle ihit=1. A datapath stalling with a held request is counted per cycle.
- ihit is never asserted in FETCH.
- No x on outputs after reset.

Test Plan:
- Cold miss: reset, imemREN=1, imemaddr=0x0000_0040, iwait=1 for 3 cycles then 0 with iload=0xDEAD_BEEF -> iREN=1, iaddr=0x40 for 4 cycles; next cycle ihit=1, imemload=0xDEADBEEF; miss_count=1, hit_count=1.
- Hit/conflict: after the fill, imemaddr=0x40 -> ihit same cycle. Then imemaddr=0x80 (same idx, different tag) -> miss and fill; then 0x40 misses again; miss_count=3.
- Address change mid-fetch: miss on 0x100; during FETCH change imemaddr to 0x204 -> iaddr stays 0x100; frame for 0x100 valid afterwards; next cycle 0x204 starts a new fill with iaddr=0x204.
- Flush: fill 0x0 and 0x4; pulse flush one cycle -> subsequent access to 0x0 misses, iREN=1. Flush on the same cycle iwait falls -> frame invalid, next access misses.
- Reset mid-fill: assert nRST while in FETCH with iwait=1 -> iREN=0, iaddr=0, ihit=0, counters 0 immediately (asynchronous); previously filled addresses miss.
- Counter wrap: CNTW=4, hold a hitting request 17 cycles -> hit_count=1.

Source files
------------

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-controller-side signals of the direct-mapped instruction cache.
// The cache uses the slave view; the datapath/memory environment uses the master view.
interface icache_direct_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        flush;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: combinational hits, single-word fills
// through the memory controller, synchronous flush and hit/miss counters.
module icache_direct #(
    parameter int FRAMES = 16,
    parameter int CNTW   = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    icache_direct_if.slave  bus,
    output logic [CNTW-1:0] hit_count,
    output logic [CNTW-1:0] miss_count
);
    localparam int IDX  = $clog2(FRAMES);
    localparam int TAGW = 30 - IDX;

    typedef enum logic {IDLE, FETCH} state_e;

    state_e            state_q, state_d;
    logic [FRAMES-1:0] valid_q;
    logic [TAGW-1:0]   tag_q  [FRAMES];
    logic [31:0]       data_q [FRAMES];
    logic [31:0]       missaddr_q, missaddr_d;
    logic [CNTW-1:0]   hit_cnt_q, miss_cnt_q;

    logic [IDX-1:0]    idx, midx;
    logic [TAGW-1:0]   atag, mtag;
    logic              hit, miss, fill;
    logic              unused_addr_lsb;

    assign idx  = bus.imemaddr[IDX+1:2];
    assign atag = bus.imemaddr[31:IDX+2];
    assign midx = missaddr_q[IDX+1:2];
    assign mtag = missaddr_q[31:IDX+2];
    assign unused_addr_lsb = ^bus.imemaddr[1:0];

    assign hit        = (state_q == IDLE) && bus.imemREN && valid_q[idx] && (tag_q[idx] == atag);
    assign miss       = (state_q == IDLE) && bus.imemREN && !hit;
    assign fill       = (state_q == FETCH) && !bus.iwait;
    assign missaddr_d = {bus.imemaddr[31:2], 2'b00};

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss) state_d = FETCH;
            FETCH:   if (!bus.iwait) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ihit     = hit;
        bus.imemload = data_q[idx];
        bus.iREN     = (state_q == FETCH);
        bus.iaddr    = (state_q == FETCH) ? missaddr_q : 32'h0;
    end

    // Flush is applied after the fill write so a coincident fill lands invalid.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            valid_q <= '0;
            for (int i = 0; i < FRAMES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            if (fill) begin
                valid_q[midx] <= 1'b1;
                tag_q[midx]   <= mtag;
                data_q[midx]  <= bus.iload;
            end
            if (bus.flush) valid_q <= '0;
        end
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            missaddr_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (miss) missaddr_q <= missaddr_d;
            if (hit)  hit_cnt_q  <= hit_cnt_q + CNTW'(1);
            if (miss) miss_cnt_q <= miss_cnt_q + CNTW'(1);
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
endmodule

// File: tb/tb_icache_direct.sv
// Directed test-plan steps followed by random traffic, checked against a
// word-address cache model kept in the bench.
module tb_icache_direct;
    localparam int          FRAMES = 16;
    localparam int          CNTW   = 4;
    localparam logic [31:0] CMASK  = (32'd1 << CNTW) - 32'd1;

    logic            CLK  = 1'b0;
    logic            nRST = 1'b1;
    logic [CNTW-1:0] hit_count, miss_count;
    int              checks = 0;
    int              errors = 0;

    icache_direct_if bus ();

    icache_direct #(.FRAMES(FRAMES), .CNTW(CNTW)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    // Model: each frame remembers the full word address it holds.
    bit          m_busy;
    logic [29:0] m_miss;
    bit          m_valid [FRAMES];
    logic [29:0] m_word  [FRAMES];
    logic [31:0] m_data  [FRAMES];
    bit          m_dunk  [FRAMES];
    int          m_hits, m_misses;

    function automatic int slot(input logic [29:0] w);
        return int'(w) % FRAMES;
    endfunction

    function automatic bit exp_hit();
        int s;
        s = slot(bus.imemaddr[31:2]);
        return !m_busy && bus.imemREN && m_valid[s] && (m_word[s] == bus.imemaddr[31:2]);
    endfunction

    task automatic model_reset();
        m_busy = 0; m_miss = '0; m_hits = 0; m_misses = 0;
        for (int i = 0; i < FRAMES; i++) begin
            m_valid[i] = 0; m_word[i] = '0; m_data[i] = '0; m_dunk[i] = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit ren, input logic [31:0] addr, input bit iw,
                         input logic [31:0] il, input bit fl);
        bus.imemREN  = ren;
        bus.imemaddr = addr;
        bus.iwait    = iw;
        bus.iload    = il;
        bus.flush    = fl;
    endtask

    task automatic mid();
        int s;
        #4;
        s = slot(bus.imemaddr[31:2]);
        chk("ihit", {31'b0, bus.ihit}, {31'b0, exp_hit()});
        if (!m_dunk[s]) chk("imemload", bus.imemload, m_data[s]);
        chk("iREN", {31'b0, bus.iREN}, {31'b0, m_busy});
        chk("iaddr", bus.iaddr, m_busy ? {m_miss, 2'b00} : 32'h0);
        chk("hit_count", 32'(hit_count), 32'(m_hits) & CMASK);
        chk("miss_count", 32'(miss_count), 32'(m_misses) & CMASK);
    endtask

    task automatic edge_();
        int k;
        @(posedge CLK);
        if (!m_busy) begin
            if (exp_hit()) m_hits++;
            else if (bus.imemREN) begin
                m_busy = 1; m_miss = bus.imemaddr[31:2]; m_misses++;
            end
        end else if (!bus.iwait) begin
            k = slot(m_miss);
            m_valid[k] = 1; m_word[k] = m_miss; m_data[k] = bus.iload;
            m_dunk[k] = bus.flush;
            m_busy = 0;
        end
        if (bus.flush)
            for (int i = 0; i < FRAMES; i++) m_valid[i] = 0;
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) begin mid(); edge_(); end
    endtask

    initial begin
        drive(0, 32'h0, 1, 32'h0, 0);
        model_reset();
        #2;
        chk("rst_ihit", {31'b0, bus.ihit}, 32'h0);
        chk("rst_imemload", bus.imemload, 32'h0);
        chk("rst_iREN", {31'b0, bus.iREN}, 32'h0);
        chk("rst_iaddr", bus.iaddr, 32'h0);
        chk("rst_hits", 32'(hit_count), 32'h0);
        chk("rst_misses", 32'(miss_count), 32'h0);
        @(posedge CLK); #1;
        nRST = 1'b0;

        // Cold miss with three stalled FETCH cycles
        drive(1, 32'h40, 1, 32'h0, 0);
        step(1);
        step(2);
        mid();
        chk("cold_iaddr", bus.iaddr, 32'h40);
        chk("cold_iREN", {31'b0, bus.iREN}, 32'h1);
        edge_();
        drive(1, 32'h40, 0, 32'hDEAD_BEEF, 0);
        step(1);
        drive(1, 32'h40, 1, 32'h0, 0);
        mid();
        chk("cold_hit", {31'b0, bus.ihit}, 32'h1);
        chk("cold_load", bus.imemload, 32'hDEAD_BEEF);
        edge_();
        mid();
        chk("cold_misses", 32'(miss_count), 32'h1);
        chk("cold_hits", 32'(hit_count), 32'h1);
        edge_();

        // Conflict on the same index
        drive(1, 32'h80, 0, 32'h0000_0080, 0);
        step(3);
        drive(1, 32'h40, 0, 32'h0000_0040, 0);
        step(1);
        mid();
        chk("conflict_misses", 32'(miss_count), 32'h3);
        edge_();
        step(1);

        // Address change during FETCH
        drive(1, 32'h100, 1, 32'h0, 0);
        step(1);
        drive(1, 32'h204, 1, 32'h0, 0);
        mid();
        chk("mf_iaddr", bus.iaddr, 32'h100);
        edge_();
        step(1);
        drive(1, 32'h204, 0, 32'h1111_2222, 0);
        step(1);
        drive(1, 32'h204, 1, 32'h0, 0);
        mid();
        chk("mf_new_miss", {31'b0, bus.ihit}, 32'h0);
        edge_();
        mid();
        chk("mf_iaddr2", bus.iaddr, 32'h204);
        edge_();
        drive(1, 32'h204, 0, 32'h3333_4444, 0);
        step(1);
        drive(1, 32'h100, 0, 32'h0, 0);
        mid();
        chk("mf_old_valid", {31'b0, bus.ihit}, 32'h1);
        chk("mf_old_data", bus.imemload, 32'h1111_2222);
        edge_();

        // Flush after filling 0x0 and 0x4
        drive(1, 32'h0, 0, 32'h0000_00A0, 0);
        step(2);
        drive(1, 32'h4, 0, 32'h0000_00A4, 0);
        step(2);
        drive(1, 32'h0, 0, 32'h0, 1);
        mid();
        chk("fl_prehit", {31'b0, bus.ihit}, 32'h1);
        edge_();
        drive(1, 32'h0, 1, 32'h0, 0);
        mid();
        chk("fl_miss", {31'b0, bus.ihit}, 32'h0);
        edge_();
        mid();
        chk("fl_iREN", {31'b0, bus.iREN}, 32'h1);
        edge_();
        drive(1, 32'h0, 0, 32'h0000_00B0, 0);
        step(1);

        // Flush coinciding with fill completion
        drive(1, 32'h8, 1, 32'h0, 0);
        step(1);
        drive(1, 32'h8, 0, 32'h0000_00C8, 1);
        step(1);
        drive(1, 32'h8, 1, 32'h0, 0);
        mid();
        chk("flc_miss", {31'b0, bus.ihit}, 32'h0);
        edge_();
        drive(1, 32'h8, 0, 32'h0000_00C9, 0);
        step(2);

        // Flush during a stalled FETCH; later completion is valid
        drive(1, 32'hC, 1, 32'h0, 0);
        step(1);
        drive(1, 32'hC, 1, 32'h0, 1);
        step(1);
        drive(1, 32'hC, 0, 32'h0000_00CC, 0);
        step(1);
        mid();
        chk("fld_hit", {31'b0, bus.ihit}, 32'h1);
        edge_();

        // Asynchronous reset mid-fill
        drive(1, 32'h40, 1, 32'h0, 0);
        step(2);
        nRST = 1'b1;
        #1;
        chk("rmf_iREN", {31'b0, bus.iREN}, 32'h0);
        chk("rmf_iaddr", bus.iaddr, 32'h0);
        chk("rmf_ihit", {31'b0, bus.ihit}, 32'h0);
        chk("rmf_hits", 32'(hit_count), 32'h0);
        chk("rmf_misses", 32'(miss_count), 32'h0);
        model_reset();
        nRST = 1'b0;
        drive(1, 32'h40, 0, 32'h0000_7777, 0);
        mid();
        chk("rmf_refill_miss", {31'b0, bus.ihit}, 32'h0);
        edge_();
        step(1);

        // Hold a hitting request 17 cycles: 4-bit hit counter wraps to 1
        step(17);
        mid();
        chk("wrap_hits", 32'(hit_count), 32'h1);
        edge_();

        // Random traffic
        repeat (400) begin
            drive($urandom_range(0, 9) < 8,
                  ({26'b0, 6'($urandom_range(0, 47))} << 2) | 32'($urandom_range(0, 3)),
                  $urandom_range(0, 2) != 0,
                  $urandom,
                  $urandom_range(0, 19) == 0);
            step(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
